// File: rtl/pipeline_ctrl_if.sv
// Hazard/sequencing bundle between the core datapath stages and pipeline_ctrl.
// master = controller side, slave = datapath side.
interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             jump_decision_id_i;
  logic             branch_decision_ex_i;
  logic [4:0]       rs1_raddr_ex_i;
  logic [4:0]       rs2_raddr_ex_i;
  logic             rs1_used_ex_i;
  logic             rs2_used_ex_i;
  logic [4:0]       regfile_waddr_mem_i;
  logic             regfile_we_mem_i;
  logic             mem_req_mem_i;
  logic             mem_we_mem_i;
  logic [4:0]       regfile_waddr_wb_i;
  logic             regfile_we_wb_i;
  logic             dbg_halt_req_i;
  logic             dbg_halt_ack_o;
  logic             stall_if_o;
  logic             stall_id_o;
  logic             stall_ex_o;
  logic             stall_me_o;
  logic             stall_wb_o;
  logic             clear_if_o;
  logic             clear_id_o;
  logic             clear_ex_o;
  logic             clear_me_o;
  logic             clear_wb_o;
  logic             pc_set_o;
  logic [1:0]       pc_mux_o;
  logic [1:0]       rs1_forward_o;
  logic [1:0]       rs2_forward_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    input  jump_decision_id_i, branch_decision_ex_i,
    input  rs1_raddr_ex_i, rs2_raddr_ex_i, rs1_used_ex_i, rs2_used_ex_i,
    input  regfile_waddr_mem_i, regfile_we_mem_i, mem_req_mem_i, mem_we_mem_i,
    input  regfile_waddr_wb_i, regfile_we_wb_i, dbg_halt_req_i,
    output dbg_halt_ack_o,
    output stall_if_o, stall_id_o, stall_ex_o, stall_me_o, stall_wb_o,
    output clear_if_o, clear_id_o, clear_ex_o, clear_me_o, clear_wb_o,
    output pc_set_o, pc_mux_o, rs1_forward_o, rs2_forward_o,
    output stall_cnt_o, flush_cnt_o
  );

  modport slave (
    output jump_decision_id_i, branch_decision_ex_i,
    output rs1_raddr_ex_i, rs2_raddr_ex_i, rs1_used_ex_i, rs2_used_ex_i,
    output regfile_waddr_mem_i, regfile_we_mem_i, mem_req_mem_i, mem_we_mem_i,
    output regfile_waddr_wb_i, regfile_we_wb_i, dbg_halt_req_i,
    input  dbg_halt_ack_o,
    input  stall_if_o, stall_id_o, stall_ex_o, stall_me_o, stall_wb_o,
    input  clear_if_o, clear_id_o, clear_ex_o, clear_me_o, clear_wb_o,
    input  pc_set_o, pc_mux_o, rs1_forward_o, rs2_forward_o,
    input  stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline: stalls/clears,
// PC redirect, EX forwarding, boot/run/debug-halt FSM and saturating perf counters.
module pipeline_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 32
) (
  input logic             clk,
  input logic             rst_n,
  pipeline_ctrl_if.master pif
);

  localparam int unsigned DrainW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {StBoot, StRun, StDrain, StHalted} state_e;

  state_e            state_q, state_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic rs1_mem_hit, rs2_mem_hit, rs1_wb_hit, rs2_wb_hit;
  logic load_use, redirect_ok, branch_take, jump_take;

  assign rs1_mem_hit = pif.rs1_used_ex_i && (pif.rs1_raddr_ex_i != 5'd0) &&
                       pif.regfile_we_mem_i && (pif.regfile_waddr_mem_i == pif.rs1_raddr_ex_i);
  assign rs2_mem_hit = pif.rs2_used_ex_i && (pif.rs2_raddr_ex_i != 5'd0) &&
                       pif.regfile_we_mem_i && (pif.regfile_waddr_mem_i == pif.rs2_raddr_ex_i);
  assign rs1_wb_hit  = pif.rs1_used_ex_i && (pif.rs1_raddr_ex_i != 5'd0) &&
                       pif.regfile_we_wb_i && (pif.regfile_waddr_wb_i == pif.rs1_raddr_ex_i);
  assign rs2_wb_hit  = pif.rs2_used_ex_i && (pif.rs2_raddr_ex_i != 5'd0) &&
                       pif.regfile_we_wb_i && (pif.regfile_waddr_wb_i == pif.rs2_raddr_ex_i);

  // Load data is only available from WB, so a load feeding EX costs one bubble.
  assign load_use = (state_q != StBoot) && pif.mem_req_mem_i && !pif.mem_we_mem_i &&
                    (rs1_mem_hit || rs2_mem_hit);

  assign redirect_ok = !load_use && ((state_q == StRun) || (state_q == StDrain));
  assign branch_take = redirect_ok && pif.branch_decision_ex_i;
  assign jump_take   = redirect_ok && pif.jump_decision_id_i && !pif.branch_decision_ex_i;

  always_comb begin
    pif.rs1_forward_o = 2'b00;
    pif.rs2_forward_o = 2'b00;
    if (state_q != StBoot) begin
      if (rs1_mem_hit)     pif.rs1_forward_o = 2'b01;
      else if (rs1_wb_hit) pif.rs1_forward_o = 2'b10;
      if (rs2_mem_hit)     pif.rs2_forward_o = 2'b01;
      else if (rs2_wb_hit) pif.rs2_forward_o = 2'b10;
    end
  end

  always_comb begin
    state_d            = state_q;
    drain_d            = drain_q;
    pif.dbg_halt_ack_o = 1'b0;
    pif.stall_if_o     = 1'b0;
    pif.stall_id_o     = 1'b0;
    pif.stall_ex_o     = 1'b0;
    pif.stall_me_o     = 1'b0;
    pif.stall_wb_o     = 1'b0;
    pif.clear_if_o     = 1'b0;
    pif.clear_id_o     = 1'b0;
    pif.clear_ex_o     = 1'b0;
    pif.clear_me_o     = 1'b0;
    pif.clear_wb_o     = 1'b0;
    pif.pc_set_o       = 1'b0;
    pif.pc_mux_o       = 2'b00;

    unique case (state_q)
      StBoot: begin
        pif.pc_set_o   = 1'b1;
        pif.pc_mux_o   = 2'b11;
        pif.clear_if_o = 1'b1;
        pif.clear_id_o = 1'b1;
        pif.clear_ex_o = 1'b1;
        pif.clear_me_o = 1'b1;
        pif.clear_wb_o = 1'b1;
        state_d        = StRun;
      end
      StRun: begin
        if (pif.dbg_halt_req_i && !load_use) begin
          state_d = StDrain;
          drain_d = DrainW'(DRAIN_CYCLES);
        end
      end
      StDrain: begin
        pif.stall_if_o = 1'b1;
        pif.clear_if_o = 1'b1;
        if (!pif.dbg_halt_req_i) begin
          state_d = StRun;
          drain_d = '0;
        end else if (!load_use) begin
          // A load-use bubble does not advance the drain, so it extends the wait.
          if (drain_q <= DrainW'(1)) begin
            state_d = StHalted;
            drain_d = '0;
          end else begin
            drain_d = drain_q - DrainW'(1);
          end
        end
      end
      StHalted: begin
        pif.stall_if_o     = 1'b1;
        pif.clear_if_o     = 1'b1;
        pif.dbg_halt_ack_o = 1'b1;
        if (!pif.dbg_halt_req_i) state_d = StRun;
      end
      default: state_d = StBoot;
    endcase

    if (load_use) begin
      pif.stall_if_o = 1'b1;
      pif.stall_id_o = 1'b1;
      pif.clear_ex_o = 1'b1;
    end

    // In DRAIN the redirect only loads the PC; fetch stays stopped via stall_if.
    if (branch_take) begin
      pif.pc_set_o   = 1'b1;
      pif.pc_mux_o   = 2'b10;
      pif.clear_if_o = 1'b1;
      pif.clear_id_o = 1'b1;
    end else if (jump_take) begin
      pif.pc_set_o   = 1'b1;
      pif.pc_mux_o   = 2'b01;
      pif.clear_if_o = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (load_use && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if ((branch_take || jump_take) && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  assign pif.stall_cnt_o = stall_cnt_q;
  assign pif.flush_cnt_o = flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StBoot;
      drain_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized self-checking bench for pipeline_ctrl against a behavioural model.
module tb_pipeline_ctrl;

  localparam int unsigned CntW        = 8;
  localparam int unsigned DrainCycles = 4;
  localparam int          CntMax      = (1 << CntW) - 1;
  localparam int          MBoot = 0, MRun = 1, MDrain = 2, MHalt = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(CntW)) pif ();

  pipeline_ctrl #(.DRAIN_CYCLES(DrainCycles), .CNT_W(CntW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pif   (pif)
  );

  int checks = 0;
  int errors = 0;

  // Model state
  int mode = MBoot;
  int drain_left = 0;
  int n_stall = 0;
  int n_flush = 0;
  bit m_lu, m_redirect;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit hit(input logic [4:0] rs, input logic used,
                             input logic we, input logic [4:0] rd);
    return used && (rs != 5'd0) && we && (rd == rs);
  endfunction

  task automatic check_outputs();
    bit boot, fetch_off, h1m, h2m, h1w, h2w, br, jp, can_redir;
    int f1, f2, mux;
    logic [4:0] exp_stall, exp_clear, got_stall, got_clear;
    boot = (mode == MBoot);
    h1m = hit(pif.rs1_raddr_ex_i, pif.rs1_used_ex_i, pif.regfile_we_mem_i, pif.regfile_waddr_mem_i);
    h2m = hit(pif.rs2_raddr_ex_i, pif.rs2_used_ex_i, pif.regfile_we_mem_i, pif.regfile_waddr_mem_i);
    h1w = hit(pif.rs1_raddr_ex_i, pif.rs1_used_ex_i, pif.regfile_we_wb_i, pif.regfile_waddr_wb_i);
    h2w = hit(pif.rs2_raddr_ex_i, pif.rs2_used_ex_i, pif.regfile_we_wb_i, pif.regfile_waddr_wb_i);
    f1 = boot ? 0 : h1m ? 1 : h1w ? 2 : 0;
    f2 = boot ? 0 : h2m ? 1 : h2w ? 2 : 0;
    m_lu = !boot && pif.mem_req_mem_i && !pif.mem_we_mem_i && (h1m || h2m);
    can_redir = !m_lu && (mode == MRun || mode == MDrain);
    br = can_redir && pif.branch_decision_ex_i;
    jp = can_redir && pif.jump_decision_id_i && !pif.branch_decision_ex_i;
    m_redirect = br || jp;
    fetch_off = (mode == MDrain) || (mode == MHalt);
    exp_stall = {fetch_off || m_lu, m_lu, 3'b000};
    exp_clear = boot ? 5'b11111 : {fetch_off || br || jp, br, m_lu, 2'b00};
    mux = boot ? 3 : br ? 2 : jp ? 1 : 0;
    got_stall = {pif.stall_if_o, pif.stall_id_o, pif.stall_ex_o, pif.stall_me_o, pif.stall_wb_o};
    got_clear = {pif.clear_if_o, pif.clear_id_o, pif.clear_ex_o, pif.clear_me_o, pif.clear_wb_o};
    check("rs1_forward", pif.rs1_forward_o, f1);
    check("rs2_forward", pif.rs2_forward_o, f2);
    check("stall_vec", got_stall, exp_stall);
    check("clear_vec", got_clear, exp_clear);
    check("pc_set", pif.pc_set_o, boot || br || jp);
    check("pc_mux", pif.pc_mux_o, mux);
    check("halt_ack", pif.dbg_halt_ack_o, mode == MHalt);
    check("stall_cnt", pif.stall_cnt_o, n_stall);
    check("flush_cnt", pif.flush_cnt_o, n_flush);
  endtask

  task automatic update_model();
    bit req;
    req = pif.dbg_halt_req_i;
    if (m_lu && n_stall < CntMax) n_stall++;
    if (m_redirect && n_flush < CntMax) n_flush++;
    case (mode)
      MBoot: mode = MRun;
      MRun: if (req && !m_lu) begin
        mode = MDrain;
        drain_left = DrainCycles;
      end
      MDrain: begin
        if (!req) begin
          mode = MRun;
          drain_left = 0;
        end else if (!m_lu) begin
          drain_left--;
          if (drain_left == 0) mode = MHalt;
        end
      end
      default: if (!req) mode = MRun;
    endcase
  endtask

  task automatic reset_model();
    mode = MBoot;
    drain_left = 0;
    n_stall = 0;
    n_flush = 0;
  endtask

  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic set_idle();
    pif.jump_decision_id_i   = 1'b0;
    pif.branch_decision_ex_i = 1'b0;
    pif.rs1_raddr_ex_i       = 5'd0;
    pif.rs2_raddr_ex_i       = 5'd0;
    pif.rs1_used_ex_i        = 1'b0;
    pif.rs2_used_ex_i        = 1'b0;
    pif.regfile_waddr_mem_i  = 5'd0;
    pif.regfile_we_mem_i     = 1'b0;
    pif.mem_req_mem_i        = 1'b0;
    pif.mem_we_mem_i         = 1'b0;
    pif.regfile_waddr_wb_i   = 5'd0;
    pif.regfile_we_wb_i      = 1'b0;
  endtask

  task automatic rand_inputs();
    pif.jump_decision_id_i   = ($urandom_range(0, 3) == 0);
    pif.branch_decision_ex_i = ($urandom_range(0, 3) == 0);
    pif.rs1_raddr_ex_i       = 5'($urandom_range(0, 3));
    pif.rs2_raddr_ex_i       = 5'($urandom_range(0, 3));
    pif.rs1_used_ex_i        = 1'($urandom);
    pif.rs2_used_ex_i        = 1'($urandom);
    pif.regfile_waddr_mem_i  = 5'($urandom_range(0, 3));
    pif.regfile_we_mem_i     = 1'($urandom);
    pif.mem_req_mem_i        = 1'($urandom);
    pif.mem_we_mem_i         = 1'($urandom);
    pif.regfile_waddr_wb_i   = 5'($urandom_range(0, 3));
    pif.regfile_we_wb_i      = 1'($urandom);
    if ($urandom_range(0, 11) == 0) pif.dbg_halt_req_i = ~pif.dbg_halt_req_i;
  endtask

  task automatic load_use_rs1(input logic [4:0] r);
    set_idle();
    pif.regfile_waddr_mem_i = r;
    pif.regfile_we_mem_i    = 1'b1;
    pif.mem_req_mem_i       = 1'b1;
    pif.rs1_raddr_ex_i      = r;
    pif.rs1_used_ex_i       = 1'b1;
  endtask

  initial begin
    set_idle();
    pif.dbg_halt_req_i = 1'b0;
    #2;
    check("reset_ack", pif.dbg_halt_ack_o, 1'b0);
    check("reset_stall_cnt", pif.stall_cnt_o, 0);
    check("reset_flush_cnt", pif.flush_cnt_o, 0);
    check("reset_pc_mux", pif.pc_mux_o, 2'b11);
    #10 rst_n = 1'b1;
    reset_model();

    // Boot cycle, then an idle RUN cycle
    cycle();
    cycle();

    // Load-use on x5, then the load reaches WB
    load_use_rs1(5'd5);
    cycle();
    check("lu_stall_cnt", pif.stall_cnt_o, 1);
    set_idle();
    pif.regfile_waddr_wb_i = 5'd5;
    pif.regfile_we_wb_i    = 1'b1;
    pif.rs1_raddr_ex_i     = 5'd5;
    pif.rs1_used_ex_i      = 1'b1;
    #1 check("lu_then_wb_fwd", pif.rs1_forward_o, 2'b10);
    cycle();

    // MEM and WB both write x3: MEM wins; x0 never forwards
    set_idle();
    pif.regfile_waddr_mem_i = 5'd3;
    pif.regfile_we_mem_i    = 1'b1;
    pif.regfile_waddr_wb_i  = 5'd3;
    pif.regfile_we_wb_i     = 1'b1;
    pif.rs2_raddr_ex_i      = 5'd3;
    pif.rs2_used_ex_i       = 1'b1;
    cycle();
    pif.regfile_waddr_mem_i = 5'd0;
    pif.regfile_waddr_wb_i  = 5'd0;
    pif.rs2_raddr_ex_i      = 5'd0;
    cycle();

    // Branch and jump together; then the same with a load-use
    set_idle();
    pif.branch_decision_ex_i = 1'b1;
    pif.jump_decision_id_i   = 1'b1;
    cycle();
    load_use_rs1(5'd7);
    pif.branch_decision_ex_i = 1'b1;
    pif.jump_decision_id_i   = 1'b1;
    cycle();

    // Halt without hazards, release, then halt with one load-use during drain
    set_idle();
    pif.dbg_halt_req_i = 1'b1;
    repeat (5) cycle();
    check("halt_after_drain", pif.dbg_halt_ack_o, 1'b1);
    pif.dbg_halt_req_i = 1'b0;
    cycle();
    check("ack_drops", pif.dbg_halt_ack_o, 1'b0);
    pif.dbg_halt_req_i = 1'b1;
    cycle();
    load_use_rs1(5'd9);
    cycle();
    set_idle();
    repeat (3) cycle();
    check("lu_extends_drain", pif.dbg_halt_ack_o, 1'b0);
    cycle();
    check("halt_after_lu_drain", pif.dbg_halt_ack_o, 1'b1);
    pif.dbg_halt_req_i = 1'b0;
    cycle();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      cycle();
    end

    // Saturate both counters
    set_idle();
    pif.dbg_halt_req_i = 1'b0;
    repeat (2) cycle();
    for (int i = 0; i < 300; i++) begin
      load_use_rs1(5'($urandom_range(1, 31)));
      cycle();
    end
    check("stall_cnt_sat", pif.stall_cnt_o, CntMax);
    set_idle();
    for (int i = 0; i < 300; i++) begin
      pif.branch_decision_ex_i = 1'($urandom);
      pif.jump_decision_id_i   = 1'b1;
      cycle();
    end
    check("flush_cnt_sat", pif.flush_cnt_o, CntMax);

    // Asynchronous reset while halted
    set_idle();
    pif.dbg_halt_req_i = 1'b1;
    repeat (6) cycle();
    check("halted_before_reset", pif.dbg_halt_ack_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ack", pif.dbg_halt_ack_o, 1'b0);
    check("async_rst_boot_mux", pif.pc_mux_o, 2'b11);
    check("async_rst_stall_cnt", pif.stall_cnt_o, 0);
    check("async_rst_flush_cnt", pif.flush_cnt_o, 0);
    reset_model();
    pif.dbg_halt_req_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
